// File: rtl/mem_iface_arbiter.sv
// mem_iface_arbiter: round-robin sharing of one 64-bit register master port between C_NUM_REQ requesters,
// with an ACK timeout so that accesses to unmapped addresses still complete.
module mem_iface_arbiter #(
    parameter int C_NUM_REQ          = 2,
    parameter int C_ADDR_WIDTH_IFACE = 16,
    parameter int C_TIMEOUT          = 64
) (
    input  logic                                    USER_CLK,
    input  logic                                    RESET,
    input  logic [C_NUM_REQ-1:0]                    REQ_EN,
    input  logic [C_NUM_REQ*C_ADDR_WIDTH_IFACE-1:0] REQ_ADDR,
    input  logic [C_NUM_REQ*64-1:0]                 REQ_DIN,
    input  logic [C_NUM_REQ*8-1:0]                  REQ_WE,
    output logic [63:0]                             REQ_DOUT,
    output logic [C_NUM_REQ-1:0]                    REQ_ACK,
    output logic                                    REQ_ERR,
    output logic                                    M_MEM_IFACE_EN,
    output logic [C_ADDR_WIDTH_IFACE-1:0]           M_MEM_IFACE_ADDR,
    output logic [63:0]                             M_MEM_IFACE_DIN,
    output logic [7:0]                              M_MEM_IFACE_WE,
    input  logic [63:0]                             M_MEM_IFACE_DOUT,
    input  logic                                    M_MEM_IFACE_ACK,
    output logic [15:0]                             TIMEOUT_CNT
);
    localparam int GW = $clog2(C_NUM_REQ);
    localparam int TW = $clog2(C_TIMEOUT) + 1;
    localparam int AW = C_ADDR_WIDTH_IFACE;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   next_grant;
    logic [GW-1:0]   cand;
    logic            found;
    logic [TW-1:0]   timer;

    // search starts one past the previous winner, giving strict rotation under full load
    always_comb begin
        next_grant = last_grant;
        cand       = '0;
        found      = 1'b0;
        for (int j = 1; j <= C_NUM_REQ; j++) begin
            cand = GW'((int'(last_grant) + j) % C_NUM_REQ);
            if (!found && REQ_EN[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            state            <= IDLE;
            grant            <= '0;
            last_grant       <= GW'(C_NUM_REQ - 1);
            timer            <= '0;
            REQ_DOUT         <= '0;
            REQ_ACK          <= '0;
            REQ_ERR          <= 1'b0;
            M_MEM_IFACE_EN   <= 1'b0;
            M_MEM_IFACE_ADDR <= '0;
            M_MEM_IFACE_DIN  <= '0;
            M_MEM_IFACE_WE   <= '0;
            TIMEOUT_CNT      <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant            <= next_grant;
                    M_MEM_IFACE_ADDR <= REQ_ADDR[next_grant*AW +: AW];
                    M_MEM_IFACE_DIN  <= REQ_DIN[next_grant*64 +: 64];
                    M_MEM_IFACE_WE   <= REQ_WE[next_grant*8 +: 8];
                    M_MEM_IFACE_EN   <= 1'b1;
                    state            <= ISSUE;
                end
                ISSUE: begin
                    M_MEM_IFACE_EN <= 1'b0;
                    timer          <= '0;
                    state          <= WAIT;
                end
                WAIT: if (M_MEM_IFACE_ACK) begin
                    REQ_DOUT <= M_MEM_IFACE_DOUT;
                    REQ_ERR  <= 1'b0;
                    REQ_ACK  <= C_NUM_REQ'(1) << grant;
                    state    <= RESP;
                end else if (timer == TW'(C_TIMEOUT - 1)) begin
                    REQ_DOUT    <= '0;
                    REQ_ERR     <= 1'b1;
                    TIMEOUT_CNT <= TIMEOUT_CNT + {15'd0, TIMEOUT_CNT != 16'hFFFF};
                    REQ_ACK     <= C_NUM_REQ'(1) << grant;
                    state       <= RESP;
                end else begin
                    timer <= timer + 1'b1;
                end
                RESP: begin
                    REQ_ACK    <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_iface_arbiter.sv
// tb_mem_iface_arbiter: scoreboard bench with a delay-programmable slave model and randomized requesters.
module tb_mem_iface_arbiter;
    localparam int N  = 2;
    localparam int AW = 16;
    localparam int T  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_en = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*64-1:0]   req_din = '0;
    logic [N*8-1:0]    req_we = '0;
    logic [63:0]       req_dout;
    logic [N-1:0]      req_ack;
    logic              req_err;
    logic              m_en;
    logic [AW-1:0]     m_addr;
    logic [63:0]       m_din;
    logic [7:0]        m_we;
    logic [63:0]       m_dout = '0;
    logic              m_ack = 1'b0;
    logic [15:0]       tcnt;

    mem_iface_arbiter #(.C_NUM_REQ(N), .C_ADDR_WIDTH_IFACE(AW), .C_TIMEOUT(T)) dut (
        .USER_CLK(clk), .RESET(rst), .REQ_EN(req_en), .REQ_ADDR(req_addr), .REQ_DIN(req_din),
        .REQ_WE(req_we), .REQ_DOUT(req_dout), .REQ_ACK(req_ack), .REQ_ERR(req_err),
        .M_MEM_IFACE_EN(m_en), .M_MEM_IFACE_ADDR(m_addr), .M_MEM_IFACE_DIN(m_din),
        .M_MEM_IFACE_WE(m_we), .M_MEM_IFACE_DOUT(m_dout), .M_MEM_IFACE_ACK(m_ack),
        .TIMEOUT_CNT(tcnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // slave model: ACK d cycles after EN (d = 0 means never), random DOUT otherwise
    int          force_d = 1;
    bit          force_dat_en = 0;
    logic [63:0] force_dat = '0;
    int          cur_d = 0;
    logic [63:0] cur_data = '0;
    logic [63:0] sdata = '0;
    int          scnt = 0;

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        return (r < 14) ? 1 + r % 4 : (r < 18) ? 63 + (r - 14) : 0;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        m_dout = {$urandom, $urandom};
        if (rst) scnt = 0;
        else begin
            if (scnt > 0) begin
                scnt--;
                if (scnt == 0) begin
                    m_ack = 1'b1;
                    m_dout = sdata;
                end
            end
            if (m_en) begin
                cur_d = (force_d >= 0) ? force_d : pick_delay();
                cur_data = force_dat_en ? force_dat : {$urandom, $urandom};
                sdata = cur_data;
                scnt = cur_d;
            end
        end
    end

    // reference model + scoreboard
    typedef struct {
        int          g;
        logic [63:0] dout;
        logic        err;
        logic [15:0] tc;
        int          when;
    } exp_t;
    exp_t        sb[$];
    int          m_last = N - 1;
    logic [15:0] tc_m = '0;
    logic [N-1:0] prev_en = '0;
    logic        prev_men = 1'b0;
    int          n_acks = 0;

    initial forever begin
        exp_t e;
        int g;
        @(negedge clk);
        if (m_en) begin
            g = -1;
            for (int j = 1; j <= N; j++)
                if (g < 0 && prev_en[(m_last + j) % N]) g = (m_last + j) % N;
            total++;
            if (g < 0 || prev_men) begin
                bad++;
                $display("FAIL m_en: got unexpected enable (pending=%b, prev_en_cycle=%0b) expected none", prev_en, prev_men);
            end else begin
                check("m_addr", m_addr, req_addr[g*AW +: AW]);
                check("m_din", m_din, req_din[g*64 +: 64]);
                check("m_we", m_we, req_we[g*8 +: 8]);
                e.g = g;
                e.err = (cur_d == 0 || cur_d > T);
                e.dout = e.err ? 64'd0 : cur_data;
                if (e.err && tc_m != 16'hFFFF) tc_m++;
                e.tc = tc_m;
                e.when = cyc + 1 + (e.err ? T : cur_d);
                sb.push_back(e);
                m_last = g;
            end
        end
        if (req_ack != '0) begin
            n_acks++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL req_ack: got %b expected no acknowledge", req_ack);
            end else begin
                logic [N-1:0] oh;
                e = sb.pop_front();
                oh = N'(1) << e.g;
                check("req_ack", req_ack, oh);
                check("req_dout", req_dout, e.dout);
                check("req_err", req_err, e.err);
                check("timeout_cnt", tcnt, e.tc);
                check("ack_cycle", cyc, e.when);
            end
        end
        prev_en = req_en;
        prev_men = m_en;
    end

    // requester driver: drop or renew a request on its ACK
    bit auto_mode = 0;
    bit keep = 0;

    task automatic rand_fields(int i);
        req_addr[i*AW +: AW] = AW'($urandom);
        req_din[i*64 +: 64] = {$urandom, $urandom};
        req_we[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_en[i] && req_ack[i]) begin
                if (keep || (auto_mode && $urandom_range(0, 1) == 1)) rand_fields(i);
                else req_en[i] = 1'b0;
            end else if (!req_en[i] && auto_mode && $urandom_range(0, 3) == 0) begin
                rand_fields(i);
                req_en[i] = 1'b1;
            end
        end
    end

    task automatic set_req(int i, logic [AW-1:0] a, logic [63:0] d, logic [7:0] w);
        @(posedge clk);
        #1;
        req_addr[i*AW +: AW] = a;
        req_din[i*64 +: 64] = d;
        req_we[i*8 +: 8] = w;
        req_en[i] = 1'b1;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((req_en != '0 || sb.size() != 0) && n < budget);
        if (req_en != '0 || sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got still busy after %0d cycles expected idle", budget);
        end
    endtask

    task automatic wait_acks(int k, int budget);
        int target, n;
        target = n_acks + k;
        n = 0;
        while (n_acks < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_acks < target) begin
            total++;
            bad++;
            $display("FAIL wait_acks: got %0d acks expected %0d", n_acks, target);
        end
    endtask

    task automatic chk_zero();
        check("rst_req_ack", req_ack, 0);
        check("rst_req_dout", req_dout, 0);
        check("rst_req_err", req_err, 0);
        check("rst_m_en", m_en, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_din", m_din, 0);
        check("rst_m_we", m_we, 0);
        check("rst_timeout_cnt", tcnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero();
        // single write, registered-ACK slave
        force_d = 1;
        set_req(0, 16'h0199, 64'h44100000, 8'hFF);
        wait_idle(200);
        // both requesting continuously
        keep = 1;
        set_req(0, 16'h0010, 64'h1111, 8'h0F);
        req_addr[AW +: AW] = 16'h0020;
        req_din[64 +: 64] = 64'h2222;
        req_we[8 +: 8] = 8'hF0;
        req_en[1] = 1'b1;
        wait_acks(4, 100);
        keep = 0;
        wait_idle(200);
        // read with known data, request dropped mid-transaction
        force_dat_en = 1;
        force_dat = 64'hCAFEF00D12345678;
        set_req(1, 16'h0040, 64'h0, 8'h00);
        repeat (2) @(posedge clk);
        #1 req_en[1] = 1'b0;
        wait_idle(200);
        force_dat_en = 0;
        // unmapped address, then normal access
        force_d = 0;
        set_req(0, 16'hDEAD, 64'h0, 8'h00);
        wait_idle(200);
        check("tcnt_after_timeout", tcnt, 1);
        force_d = 1;
        set_req(1, 16'h0300, 64'h5, 8'h01);
        wait_idle(200);
        // ACK on the last allowed cycle wins; one later times out
        force_d = T;
        set_req(0, 16'h0400, 64'h6, 8'h03);
        wait_idle(200);
        check("tcnt_ack_at_limit", tcnt, 1);
        force_d = T + 1;
        set_req(1, 16'h0500, 64'h7, 8'h00);
        wait_idle(200);
        check("tcnt_ack_past_limit", tcnt, 2);
        // reset during WAIT
        force_d = 0;
        set_req(1, 16'h0600, 64'h8, 8'h00);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        m_last = N - 1;
        tc_m = '0;
        req_addr[0 +: AW] = 16'h0700;
        req_din[0 +: 64] = 64'h9;
        req_we[0 +: 8] = 8'h0C;
        req_en[0] = 1'b1;
        force_d = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero();
        wait_idle(200);
        // randomized traffic
        force_d = -1;
        auto_mode = 1;
        repeat (4000) @(posedge clk);
        #1 auto_mode = 0;
        wait_idle(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_iface_arbiter.md
Name: mem_iface_arbiter

Overview:
- Shares one 64-bit register-access master port (EN/ADDR/DIN/WE/DOUT/ACK) between C_NUM_REQ requesters, e.g. host PCIe BAR access and the on-chip configuration sequencer.
- Downstream slaves include the address translator and DMA register banks.
- Grants one transaction at a time, round-robin, and issues a single-cycle EN downstream.
- Waits for ACK, or generates a timeout error response, so no requester hangs on an unmapped address.

Parameters:
- C_NUM_REQ, 2, number of requesters (2..8).
- C_ADDR_WIDTH_IFACE, 16, register address width.
- C_TIMEOUT, 64, cycles waited for ACK after EN before an error response (≥2).

Ports:
- USER_CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- REQ_EN  in  C_NUM_REQ  per-requester request; held until REQ_ACK.
- REQ_ADDR  in  C_NUM_REQ*C_ADDR_WIDTH_IFACE  packed addresses, requester i at slice i.
- REQ_DIN  in  C_NUM_REQ*64  packed write data.
- REQ_WE  in  C_NUM_REQ*8  packed byte enables; 0 means read.
- REQ_DOUT  out  64  read data, valid with REQ_ACK.
- REQ_ACK  out  C_NUM_REQ  one-hot completion pulse.
- REQ_ERR  out  1  timeout flag, valid with REQ_ACK.
- M_MEM_IFACE_EN  out  1  downstream enable.
- M_MEM_IFACE_ADDR  out  C_ADDR_WIDTH_IFACE  downstream address.
- M_MEM_IFACE_DIN  out  64  downstream write data.
- M_MEM_IFACE_WE  out  8  downstream byte enables.
- M_MEM_IFACE_DOUT  in  64  downstream read data.
- M_MEM_IFACE_ACK  in  1  downstream acknowledge.
- TIMEOUT_CNT  out  16  saturating count of timed-out transactions.

Behaviour:
- Clock and reset: one clock, USER_CLK. RESET is synchronous and active-high.
- Registered outputs: all outputs are registers.
- Reset values:
  - FSM goes to IDLE.
  - All outputs are 0, including TIMEOUT_CNT.
  - last_grant = C_NUM_REQ-1, so requester 0 wins first.
  - An in-flight transaction is abandoned with no ACK.
- IDLE:
  - If any REQ_EN bit is set, grant the first set bit searching from last_grant+1, wrapping modulo C_NUM_REQ.
  - Latch that requester's ADDR/DIN/WE into the M_ side registers, then go to ISSUE.
- ISSUE:
  - M_MEM_IFACE_EN = 1 for exactly this cycle; ADDR/DIN/WE are stable.
  - Clear the timer, then go to WAIT.
- WAIT:
  - EN = 0. ADDR/DIN/WE are held until RESP.
  - If M_MEM_IFACE_ACK = 1: capture M_MEM_IFACE_DOUT, set err = 0, go to RESP.
  - Else the timer increments. When the timer reaches C_TIMEOUT-1 with no ACK: data = 0, err = 1, TIMEOUT_CNT += 1 (saturating at 16'hFFFF), go to RESP.
  - ACK and the timeout limit in the same cycle: ACK wins, no error.
- ACK outside WAIT: ignored, no state change.
- RESP:
  - REQ_ACK[grant] = 1 for one cycle; REQ_DOUT and REQ_ERR are driven.
  - last_grant = grant, then go to IDLE.
  - REQ_DOUT/REQ_ERR hold their values until the next RESP.
- Latency:
  - A slave with a registered ACK (ACK one cycle after EN) gives REQ_ACK 3 cycles after REQ_EN is first sampled in IDLE.
  - Back-to-back transactions: one transaction every 4 cycles.
- Requester rules:
  - REQ_EN deasserted mid-transaction: the transaction still completes and is acknowledged; the arbiter never aborts.
  - REQ_EN still high in the cycle after REQ_ACK: treated as a new request and arbitrated normally (round-robin position already advanced).
- Fairness: with all requesters continuously requesting, grants rotate strictly 0,1,…,N-1,0.
- Downstream: no write/read distinction in the arbiter; WE is passed through unchanged.
- Timer width: $clog2(C_TIMEOUT)+1 bits.

Test Plan:
- Reset, then requester 0 write ADDR=16'h199, DIN=64'h44100000, WE=8'hFF; slave ACKs 1 cycle after EN:
  - one-cycle M_EN with those values;
  - REQ_ACK=2'b01 3 cycles after the request;
  - REQ_ERR=0.
- REQ_EN=2'b11 held continuously across 4 transactions: grants in order 0,1,0,1; each REQ_ACK is one-hot; no grant skipped.
- Requester 1 read, slave returns DOUT=64'hCAFEF00D12345678 with ACK: REQ_DOUT equals that value in the REQ_ACK cycle.
- Read to an unmapped address, no ACK, C_TIMEOUT=64:
  - REQ_ACK asserted with REQ_ERR=1 and REQ_DOUT=0;
  - TIMEOUT_CNT goes 0→1;
  - the next request is serviced normally.
- ACK arrives in the same cycle the timer hits C_TIMEOUT-1: REQ_ERR=0, TIMEOUT_CNT unchanged.
- RESET asserted during WAIT: no REQ_ACK is emitted, outputs go to 0, and the next request is granted to requester 0 first.
